// File: rtl/led_seq_pkg.sv
// led_seq_pkg: state encoding and width constants shared by the
// LED bin sequencer and its next-bin finder.
package led_seq_pkg;

    localparam int LEDS_DEF    = 50;
    localparam int BIN_QTY_DEF = 12;

    localparam int CNT_W    = $clog2(LEDS_DEF);
    localparam int BIN_W    = $clog2(BIN_QTY_DEF);
    localparam int LEDCNT_W = $clog2(LEDS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/led_next_bin.sv
// led_next_bin: lowest-index bin at or after 'start' with a nonzero count.
// Instantiated only when LEDSEQ_SKIP_ZERO_EN is defined.
module led_next_bin
    import led_seq_pkg::*;
#(
    parameter int BIN_QTY = BIN_QTY_DEF,
    parameter int CW      = CNT_W,
    parameter int BW      = BIN_W
) (
    input  logic [BIN_QTY*CW-1:0] counts,
    input  logic [BW:0]           start,
    output logic                  found,
    output logic [BW-1:0]         idx
);

    // Walk downwards so the lowest qualifying bin is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = BIN_QTY - 1; i >= 0; i--) begin
            if (i >= int'(start) && counts[i*CW +: CW] != '0) begin
                found = 1'b1;
                idx   = BW'(i);
            end
        end
    end

endmodule

// File: rtl/led_bin_sequencer.sv
// led_bin_sequencer: expands a frame of per-bin LED counts into LEDS
// per-LED transfers. Optional LEDSEQ_SKIP_ZERO_EN removes zero-bin bubbles.
module led_bin_sequencer
    import led_seq_pkg::*;
#(
    parameter int LEDS    = LEDS_DEF,
    parameter int BIN_QTY = BIN_QTY_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BIN_QTY*$clog2(LEDS)-1:0]     LEDCount_i,
    input  logic                                data_v,
    output logic [$clog2(BIN_QTY)-1:0]          ledBin_o,
    output logic                                ledOn_o,
    output logic                                ledValid_o,
    input  logic                                ledReady_i,
    output logic                                ledLast_o,
    output logic                                busy_o,
    output logic                                overrun_o
);

    localparam int CW = $clog2(LEDS);
    localparam int BW = $clog2(BIN_QTY);
    localparam int LW = $clog2(LEDS + 1);

    seq_state_e          state_q, state_d;
    logic [BW-1:0]       ptr_q, ptr_d;
    logic [LW-1:0]       lcnt_q, lcnt_d;
    logic [BIN_QTY*CW-1:0] cnt_q, cnt_d;
    logic                ovr_q, ovr_d;

    logic [CW-1:0]       cur;
    logic                xfer;
    logic                last_x;
    logic                adv_pad;
    logic [BW-1:0]       adv_ptr;

    assign cur    = cnt_q[int'(ptr_q)*CW +: CW];
    assign xfer   = ledValid_o && ledReady_i;
    assign last_x = xfer && (lcnt_q == LW'(LEDS - 1));

`ifdef LEDSEQ_SKIP_ZERO_EN
    logic [BIN_QTY*CW-1:0] nb_counts;
    logic [BW:0]           nb_start;
    logic                  nb_found;
    logic [BW-1:0]         nb_idx;

    // In IDLE search the incoming frame from bin 0, otherwise the latched
    // counts strictly after the current bin.
    always_comb begin
        nb_counts = cnt_q;
        nb_start  = {1'b0, ptr_q} + 1'b1;
        if (state_q == IDLE) begin
            nb_counts = LEDCount_i;
            nb_start  = '0;
        end
    end

    led_next_bin #(
        .BIN_QTY (BIN_QTY),
        .CW      (CW),
        .BW      (BW)
    ) u_next_bin (
        .counts (nb_counts),
        .start  (nb_start),
        .found  (nb_found),
        .idx    (nb_idx)
    );

    always_comb begin
        adv_pad = !nb_found;
        adv_ptr = nb_idx;
    end
`else
    always_comb begin
        adv_pad = (ptr_q == BW'(BIN_QTY - 1));
        adv_ptr = ptr_q + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lcnt_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lcnt_q  <= lcnt_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lcnt_d  = lcnt_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (data_v) begin
                    cnt_d  = LEDCount_i;
                    lcnt_d = '0;
                    ovr_d  = 1'b0;
                    ptr_d  = '0;
                    state_d = EMIT;
`ifdef LEDSEQ_SKIP_ZERO_EN
                    ptr_d   = nb_idx;
                    state_d = nb_found ? EMIT : PAD;
`endif
                end
            end
            EMIT: begin
                // An empty bin is a bubble cycle spent moving the pointer.
                if (cur == '0) begin
                    ptr_d   = adv_pad ? '0 : adv_ptr;
                    state_d = adv_pad ? PAD : EMIT;
                end else if (xfer) begin
                    cnt_d[int'(ptr_q)*CW +: CW] = cur - 1'b1;
                    lcnt_d = lcnt_q + 1'b1;
                    if (last_x) begin
                        state_d = IDLE;
                    end else if (cur == CW'(1)) begin
                        ptr_d   = adv_pad ? '0 : adv_ptr;
                        state_d = adv_pad ? PAD : EMIT;
                    end
                end
            end
            PAD: begin
                if (xfer) begin
                    lcnt_d = lcnt_q + 1'b1;
                    if (last_x) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (data_v && state_q != IDLE) ovr_d = 1'b1;
    end

    always_comb begin
        ledValid_o = 1'b0;
        ledOn_o    = 1'b0;
        ledBin_o   = '0;
        unique case (state_q)
            EMIT: begin
                if (cur != '0) begin
                    ledValid_o = 1'b1;
                    ledOn_o    = 1'b1;
                    ledBin_o   = ptr_q;
                end
            end
            PAD:     ledValid_o = 1'b1;
            default: ledValid_o = 1'b0;
        endcase
        ledLast_o = ledValid_o && (lcnt_q == LW'(LEDS - 1));
        busy_o    = (state_q != IDLE);
        overrun_o = ovr_q;
    end

endmodule
